// File: rtl/sm83_pkg.sv
// Shared SM83 core types: decoded control ops, fetch sequencer states and
// the immediate-length lookup used by the fetch sequencer.
package sm83_pkg;

  typedef enum logic [5:0] {
    CTL_NOP,
    CTL_HALT,
    CTL_STOP,
    CTL_LD_R8_R8,
    CTL_ALU_R8,
    CTL_LD_R8_D8,
    CTL_LDPTR_HL_D8,
    CTL_JR,
    CTL_JR_COND,
    CTL_ALU_A_D8,
    CTL_LDPTR_A8_A,
    CTL_LDPTR_A_A8,
    CTL_ADD_SP_D8,
    CTL_LD_HL_SP_D8,
    CTL_LD_R16_D16,
    CTL_LDPTR_D16_SP,
    CTL_JP_A16,
    CTL_JP_COND,
    CTL_CALL_A16,
    CTL_CALL_COND_A16,
    CTL_LDPTR_A16_A,
    CTL_LDPTR_A_A16,
    CTL_ILLEGAL
  } ctl_op_t;

  typedef enum logic [2:0] {
    StFetchOp,
    StDecode,
    StFetchCb,
    StFetchLo,
    StFetchHi,
    StIssue,
    StHalted
  } fetch_state_t;

  // Number of immediate bytes that follow the opcode for a decoded op.
  function automatic logic [1:0] imm_bytes(input ctl_op_t op);
    case (op)
      CTL_LD_R8_D8, CTL_LDPTR_HL_D8, CTL_JR, CTL_JR_COND, CTL_ALU_A_D8,
      CTL_LDPTR_A8_A, CTL_LDPTR_A_A8, CTL_ADD_SP_D8, CTL_LD_HL_SP_D8:
        imm_bytes = 2'd1;
      CTL_LD_R16_D16, CTL_LDPTR_D16_SP, CTL_JP_A16, CTL_JP_COND, CTL_CALL_A16,
      CTL_CALL_COND_A16, CTL_LDPTR_A16_A, CTL_LDPTR_A_A16:
        imm_bytes = 2'd2;
      default:
        imm_bytes = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_seq.sv
// SM83 instruction fetch sequencer: owns PC and IR, walks the external
// decoder (including the CB-prefix loop), gathers immediates and hands each
// complete instruction to execute over a valid/ready handshake.
module fetch_seq
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  dec_instr,
  output logic        dec_is_instr16,
  input  logic        dec_o_is_instr16,
  input  ctl_op_t     dec_ctl_op,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [7:0]  iss_opcode,
  output logic        iss_is_cb,
  output ctl_op_t     iss_ctl_op,
  output logic [15:0] iss_imm,
  output logic [15:0] iss_next_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        wake
);

  fetch_state_t r_state, w_state_next;
  logic [15:0]  r_pc;
  logic [7:0]   r_ir;
  logic         r_cb;
  logic [15:0]  r_imm;
  ctl_op_t      r_ctl_op;
  logic [1:0]   r_n;

  // A CB prefix seen on the first decode pass defers the real decode.
  logic w_need_cb;
  assign w_need_cb = dec_o_is_instr16 & ~r_cb;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetchOp;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; redirect overrides everything, including a same-cycle ack.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = StFetchOp;
    end else begin
      unique case (r_state)
        StFetchOp: if (mem_ack) w_state_next = StDecode;
        StDecode: begin
          if (w_need_cb) begin
            w_state_next = StFetchCb;
          end else if (imm_bytes(dec_ctl_op) == 2'd0) begin
            w_state_next = StIssue;
          end else begin
            w_state_next = StFetchLo;
          end
        end
        StFetchCb: if (mem_ack) w_state_next = StDecode;
        StFetchLo: if (mem_ack) w_state_next = (r_n == 2'd2) ? StFetchHi : StIssue;
        StFetchHi: if (mem_ack) w_state_next = StIssue;
        StIssue: begin
          if (iss_ready) begin
            w_state_next = (r_ctl_op == CTL_HALT || r_ctl_op == CTL_STOP) ? StHalted
                                                                            : StFetchOp;
          end
        end
        StHalted: if (wake) w_state_next = StFetchOp;
        default: w_state_next = StFetchOp;
      endcase
    end
  end

  // Outputs are pure functions of state and the datapath registers.
  always_comb begin
    mem_req        = 1'b0;
    iss_valid      = 1'b0;
    unique case (r_state)
      StFetchOp, StFetchCb, StFetchLo, StFetchHi: mem_req = 1'b1;
      StIssue:                                    iss_valid = 1'b1;
      default: ;
    endcase
    mem_addr       = r_pc;
    dec_instr      = r_ir;
    dec_is_instr16 = r_cb;
    iss_opcode     = r_ir;
    iss_is_cb      = r_cb;
    iss_ctl_op     = r_ctl_op;
    iss_imm        = r_imm;
    iss_next_pc    = r_pc;
  end

  // Datapath: PC, IR, CB flag, immediate and latched control op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_ir     <= 8'h00;
      r_cb     <= 1'b0;
      r_imm    <= 16'h0000;
      r_ctl_op <= CTL_NOP;
      r_n      <= 2'd0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      r_cb <= 1'b0;
    end else begin
      case (r_state)
        StFetchOp, StFetchCb: begin
          if (mem_ack) begin
            r_ir  <= mem_rdata;
            r_cb  <= (r_state == StFetchCb);
            r_pc  <= r_pc + 16'd1;
            r_imm <= 16'h0000;
          end
        end
        StDecode: begin
          if (!w_need_cb) begin
            r_ctl_op <= dec_ctl_op;
            r_n      <= imm_bytes(dec_ctl_op);
          end
        end
        StFetchLo: begin
          if (mem_ack) begin
            r_imm[7:0] <= mem_rdata;
            r_pc       <= r_pc + 16'd1;
          end
        end
        StFetchHi: begin
          if (mem_ack) begin
            r_imm[15:8] <= mem_rdata;
            r_pc        <= r_pc + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: byte-addressed memory with optional wait
// states, a tiny opcode decoder, and hand-computed expectations.
module tb_fetch_seq;
  import sm83_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  dec_instr;
  logic        dec_is_instr16;
  logic        dec_o_is_instr16;
  ctl_op_t     dec_ctl_op;
  logic        iss_valid;
  logic        iss_ready;
  logic [7:0]  iss_opcode;
  logic        iss_is_cb;
  ctl_op_t     iss_ctl_op;
  logic [15:0] iss_imm;
  logic [15:0] iss_next_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        wake;

  logic [7:0]  mem [0:65535];
  logic        ack_en;
  logic [15:0] addr_q[$];
  logic [15:0] dis_hist;
  int          n_checks;
  int          n_fail;
  int          cyc;

  fetch_seq #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .dec_instr       (dec_instr),
    .dec_is_instr16  (dec_is_instr16),
    .dec_o_is_instr16(dec_o_is_instr16),
    .dec_ctl_op      (dec_ctl_op),
    .iss_valid       (iss_valid),
    .iss_ready       (iss_ready),
    .iss_opcode      (iss_opcode),
    .iss_is_cb       (iss_is_cb),
    .iss_ctl_op      (iss_ctl_op),
    .iss_imm         (iss_imm),
    .iss_next_pc     (iss_next_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .wake            (wake)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory unless ack_en is dropped.
  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem[mem_addr];

  // Minimal decoder covering the opcodes used below.
  always_comb begin
    dec_o_is_instr16 = 1'b0;
    dec_ctl_op       = CTL_NOP;
    if (dec_is_instr16) begin
      dec_ctl_op = CTL_ALU_R8;
    end else begin
      case (dec_instr)
        8'h01:   dec_ctl_op = CTL_LD_R16_D16;
        8'h06:   dec_ctl_op = CTL_LD_R8_D8;
        8'h10:   dec_ctl_op = CTL_STOP;
        8'h76:   dec_ctl_op = CTL_HALT;
        8'hC3:   dec_ctl_op = CTL_JP_A16;
        8'hCB:   dec_o_is_instr16 = 1'b1;
        default: dec_ctl_op = CTL_NOP;
      endcase
    end
  end

  // Record addresses of completed (non-redirected) reads.
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack && !redirect_valid) addr_q.push_back(mem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step cycles (sampled 1ns after the edge) until iss_valid or the budget runs out.
  task automatic wait_valid(input int max_cyc, output int ncyc);
    ncyc = 1;
    dis_hist = '0;
    dis_hist[1] = dec_is_instr16;
    while (!iss_valid && ncyc < max_cyc) begin
      @(posedge clk);
      #1;
      ncyc++;
      dis_hist[ncyc[3:0]] = dec_is_instr16;
    end
  endtask

  task automatic accept();
    iss_ready = 1'b1;
    @(posedge clk);
    #1;
    iss_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    ack_en = 1'b1;
    iss_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    wake = 1'b0;

    // Program image.
    mem[16'h0001] = 8'h01; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;
    mem[16'h0004] = 8'hCB; mem[16'h0005] = 8'h37;
    mem[16'h0006] = 8'h06; mem[16'h0007] = 8'h55;
    mem[16'hFFFE] = 8'hC3; mem[16'hFFFF] = 8'h00;
    mem[16'h0100] = 8'h76;
    mem[16'h0101] = 8'h06; mem[16'h0102] = 8'h99;
    mem[16'h0201] = 8'h01; mem[16'h0202] = 8'hAA; mem[16'h0203] = 8'hBB;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check_eq("rst_mem_req", 32'(mem_req), 32'd1);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0000);
    check_eq("rst_iss_valid", 32'(iss_valid), 32'd0);
    check_eq("rst_dec_instr", 32'(dec_instr), 32'h00);
    check_eq("rst_dec_cb", 32'(dec_is_instr16), 32'd0);
    check_eq("rst_imm", 32'(iss_imm), 32'h0000);
    check_eq("rst_ctl", 32'(iss_ctl_op), 32'(CTL_NOP));

    // NOP at 0x0000: valid in cycle 3.
    wait_valid(12, cyc);
    check_eq("nop_valid", 32'(iss_valid), 32'd1);
    check_eq("nop_lat", 32'(cyc), 32'd3);
    check_eq("nop_opcode", 32'(iss_opcode), 32'h00);
    check_eq("nop_ctl", 32'(iss_ctl_op), 32'(CTL_NOP));
    check_eq("nop_next_pc", 32'(iss_next_pc), 32'h0001);
    accept();
    addr_q.delete();

    // LD r16,d16 at 0x0001.
    wait_valid(12, cyc);
    check_eq("ld16_valid", 32'(iss_valid), 32'd1);
    check_eq("ld16_lat", 32'(cyc), 32'd5);
    check_eq("ld16_ctl", 32'(iss_ctl_op), 32'(CTL_LD_R16_D16));
    check_eq("ld16_imm", 32'(iss_imm), 32'h1234);
    check_eq("ld16_next_pc", 32'(iss_next_pc), 32'h0004);
    check_eq("ld16_nreads", 32'(addr_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("ld16_addr%0d", k),
               (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hFFFF_FFFF, 32'(k + 1));
    end
    accept();

    // CB 37 at 0x0004.
    wait_valid(12, cyc);
    check_eq("cb_valid", 32'(iss_valid), 32'd1);
    check_eq("cb_lat", 32'(cyc), 32'd5);
    check_eq("cb_dec16_first", 32'(dis_hist[2]), 32'd0);
    check_eq("cb_dec16_second", 32'(dis_hist[4]), 32'd1);
    check_eq("cb_is_cb", 32'(iss_is_cb), 32'd1);
    check_eq("cb_opcode", 32'(iss_opcode), 32'h37);
    check_eq("cb_ctl", 32'(iss_ctl_op), 32'(CTL_ALU_R8));
    check_eq("cb_next_pc", 32'(iss_next_pc), 32'h0006);
    accept();

    // LD r8,d8 at 0x0006 with back-pressure; wake must be ignored in ISSUE.
    wait_valid(12, cyc);
    check_eq("d8_lat", 32'(cyc), 32'd4);
    check_eq("d8_is_cb", 32'(iss_is_cb), 32'd0);
    for (int k = 0; k < 3; k++) begin
      wake = (k == 1);
      @(posedge clk);
      #1;
      check_eq("bp_valid", 32'(iss_valid), 32'd1);
      check_eq("bp_mem_req", 32'(mem_req), 32'd0);
      check_eq("bp_imm", 32'(iss_imm), 32'h0055);
      check_eq("bp_next_pc", 32'(iss_next_pc), 32'h0008);
    end
    wake = 1'b0;
    check_eq("d8_ctl", 32'(iss_ctl_op), 32'(CTL_LD_R8_D8));
    accept();

    // JP a16 straddling the 0xFFFF -> 0x0000 wrap.
    mem[16'h0000] = 8'h80;
    redirect(16'hFFFE);
    check_eq("wrap_addr0", 32'(mem_addr), 32'hFFFE);
    wait_valid(12, cyc);
    check_eq("wrap_lat", 32'(cyc), 32'd5);
    check_eq("wrap_opcode", 32'(iss_opcode), 32'hC3);
    check_eq("wrap_ctl", 32'(iss_ctl_op), 32'(CTL_JP_A16));
    check_eq("wrap_imm", 32'(iss_imm), 32'h8000);
    check_eq("wrap_next_pc", 32'(iss_next_pc), 32'h0001);
    accept();

    // HALT: idle with no requests until wake.
    redirect(16'h0100);
    wait_valid(12, cyc);
    check_eq("halt_lat", 32'(cyc), 32'd3);
    check_eq("halt_ctl", 32'(iss_ctl_op), 32'(CTL_HALT));
    check_eq("halt_next_pc", 32'(iss_next_pc), 32'h0101);
    accept();
    for (int k = 0; k < 5; k++) begin
      check_eq("halt_mem_req", 32'(mem_req), 32'd0);
      check_eq("halt_valid", 32'(iss_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    wake = 1'b1;
    @(posedge clk);
    #1;
    wake = 1'b0;
    check_eq("wake_mem_req", 32'(mem_req), 32'd1);
    check_eq("wake_mem_addr", 32'(mem_addr), 32'h0101);

    // Redirect colliding with the FETCH_LO ack drops the byte.
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("lo_addr", 32'(mem_addr), 32'h0102);
    check_eq("lo_mem_req", 32'(mem_req), 32'd1);
    redirect(16'h0200);
    check_eq("redir_addr", 32'(mem_addr), 32'h0200);
    check_eq("redir_valid", 32'(iss_valid), 32'd0);
    check_eq("redir_cb", 32'(dec_is_instr16), 32'd0);
    // Wait states hold the address.
    ack_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("ws_addr", 32'(mem_addr), 32'h0200);
      check_eq("ws_mem_req", 32'(mem_req), 32'd1);
      check_eq("ws_valid", 32'(iss_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    ack_en = 1'b1;
    wait_valid(12, cyc);
    check_eq("redir_lat", 32'(cyc), 32'd3);
    check_eq("redir_opcode", 32'(iss_opcode), 32'h00);
    check_eq("redir_ctl", 32'(iss_ctl_op), 32'(CTL_NOP));
    check_eq("redir_imm", 32'(iss_imm), 32'h0000);
    check_eq("redir_next_pc", 32'(iss_next_pc), 32'h0201);
    accept();

    // Asynchronous reset in the middle of FETCH_LO.
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("mid_addr", 32'(mem_addr), 32'h0202);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_addr", 32'(mem_addr), 32'h0000);
    check_eq("arst_mem_req", 32'(mem_req), 32'd1);
    check_eq("arst_valid", 32'(iss_valid), 32'd0);
    check_eq("arst_instr", 32'(dec_instr), 32'h00);
    check_eq("arst_imm", 32'(iss_imm), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(12, cyc);
    check_eq("post_rst_lat", 32'(cyc), 32'd3);
    check_eq("post_rst_opcode", 32'(iss_opcode), 32'h80);
    check_eq("post_rst_next_pc", 32'(iss_next_pc), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch sequencer for the SM83 core. Owns the program counter and the instruction register. Drives the combinational decode stage, including its 0xCB-prefix feedback loop, and fetches 0, 1 or 2 immediate bytes as the decoded control op requires. Presents each complete instruction to execute over a valid/ready handshake. Sits between the memory bus port and the execute stage; execute steers it through redirect and wake.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  byte read request, held until mem_ack.
- mem_addr  out  16  read address, stable while mem_req.
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  read data.
- dec_instr  out  8  instruction register to decode `instr`.
- dec_is_instr16  out  1  to decode `i_is_instr16`; 1 while ir holds a CB-page byte.
- dec_o_is_instr16  in  1  from decode `o_is_instr16`.
- dec_ctl_op  in  ctl_op_t  from decode `ctl_op`.
- iss_valid  out  1  complete instruction available.
- iss_ready  in  1  execute accepts.
- iss_opcode  out  8  opcode byte (the byte after CB for CB ops).
- iss_is_cb  out  1  CB-page instruction.
- iss_ctl_op  out  ctl_op_t  latched ctl_op.
- iss_imm  out  16  immediate, {hi,lo}; a 1-byte immediate goes in [7:0] with [15:8]=0.
- iss_next_pc  out  16  address after the last byte of the instruction.
- redirect_valid  in  1  load new PC and abort the current sequence.
- redirect_pc  in  16  new PC.
- wake  in  1  leave the HALTED state.

## Operation
States: FETCH_OP, DECODE, FETCH_CB, FETCH_LO, FETCH_HI, ISSUE, HALTED.

- FETCH_OP:
  - mem_req=1, mem_addr=pc.
  - On ack: ir<=rdata, cb<=0, pc<=pc+1, go to DECODE.
- DECODE (one cycle):
  - dec_instr=ir, dec_is_instr16=cb.
  - If dec_o_is_instr16 and !cb: go to FETCH_CB.
  - Otherwise latch ctl_op and set n=imm_bytes(ctl_op).
  - n=0: go to ISSUE. n=1: go to FETCH_LO. n=2: go to FETCH_LO, then FETCH_HI.
- FETCH_CB:
  - mem_addr=pc.
  - On ack: ir<=rdata, cb<=1, pc<=pc+1, go to DECODE.
- FETCH_LO and FETCH_HI:
  - mem_addr=pc.
  - On ack: store the byte, pc<=pc+1.
  - FETCH_LO goes to FETCH_HI if n=2, otherwise to ISSUE. FETCH_HI goes to ISSUE.
  - imm is cleared on entry to DECODE.
- ISSUE:
  - iss_valid=1; all iss_* outputs are stable until the handshake.
  - On iss_valid&iss_ready: go to HALTED if ctl_op is CTL_HALT or CTL_STOP, otherwise go to FETCH_OP.
- HALTED:
  - mem_req=0.
  - On wake: go to FETCH_OP. wake is ignored in all other states.
- redirect_valid:
  - Accepted in every state and has top priority.
  - Next cycle: pc<=redirect_pc, state=FETCH_OP, cb<=0, iss_valid=0.
  - An ack or issue handshake in the same cycle is discarded and does not advance pc.
  - The memory port must tolerate withdrawal of mem_req without ack.
- PC arithmetic is 16-bit modulo: 0xFFFF+1 wraps to 0x0000, including mid-instruction.
- iss_next_pc equals pc in ISSUE.

## Timing
- Reset values:
  - state=FETCH_OP, pc=RESET_PC, ir=0, cb=0, imm=0, ctl_op=CTL_NOP.
  - mem_req=1 from the first cycle after reset release; mem_addr=RESET_PC.
  - iss_valid=0.
- Latency with zero-wait memory (ack in the cycle after the request is raised counts as 1 cycle per byte):
  - NOP-class: FETCH_OP(1)+DECODE(1) gives iss_valid in cycle 3.
  - d8: +1 cycle. d16: +2 cycles. CB: +2 cycles (FETCH_CB + second DECODE).
- Wait states stretch any FETCH_* state indefinitely; mem_addr holds.
- Issue back-pressure: ISSUE holds with no fetch prefetch; mem_req=0 in ISSUE.
- Reset assertion mid-fetch: immediate return to reset values; no handshake completes.

## Structure
- Add to sm83_pkg:
  - fetch_state_t enum.
  - function imm_bytes(ctl_op_t) returning logic [1:0].
- imm_bytes values:
  - 1 for CTL_LD_R8_D8, CTL_LDPTR_HL_D8, CTL_JR, CTL_JR_COND, CTL_ALU_A_D8, CTL_LDPTR_A8_A, CTL_LDPTR_A_A8, CTL_ADD_SP_D8, CTL_LD_HL_SP_D8.
  - 2 for CTL_LD_R16_D16, CTL_LDPTR_D16_SP, CTL_JP_A16, CTL_JP_COND, CTL_CALL_A16, CTL_CALL_COND_A16, CTL_LDPTR_A16_A, CTL_LDPTR_A_A16.
  - 0 otherwise.
- The decode module is instantiated outside fetch_seq (in the core top), not inside it; no sub-module is needed.

## Test plan
- Memory 0x0000={0x00}, zero-wait, iss_ready=1 -> iss_valid in cycle 3: opcode 0x00, ctl_op CTL_NOP, next_pc 0x0001.
- Bytes {0x01,0x34,0x12} at 0x0000 -> one issue: CTL_LD_R16_D16, imm 0x1234, next_pc 0x0003. mem_addr sequence 0,1,2.
- Bytes {0xCB,0x37} -> iss_is_cb=1, opcode 0x37, ctl_op CTL_ALU_R8. dec_is_instr16=1 only in the second DECODE.
- PC=0xFFFE with {0xC3,0x00} then 0x0000={0x80} -> JP imm_lo=0x00 at 0xFFFF, imm_hi=0x80 from wrapped 0x0000; imm 0x8000, next_pc 0x0001.
- 0x76 issued, then 5 idle cycles -> mem_req=0 throughout. Pulse wake -> FETCH_OP at pc 0x0001.
- redirect_valid (pc=0x0200) in the same cycle as mem_ack in FETCH_LO -> byte dropped, no issue, next mem_addr=0x0200.
